// File: rtl/misr_signature_checker.sv
// Multiple-input signature register that compacts N_PATTERNS response words
// and compares the final signature against a golden value.
module misr_signature_checker #(
    parameter int               WIDTH      = 3,
    parameter int               N_PATTERNS = 7,
    parameter logic [WIDTH-1:0] TAPS0      = 3'b011,
    parameter logic [WIDTH-1:0] TAPS1      = 3'b101,
    parameter logic [WIDTH-1:0] SEED       = 3'b000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Poly,
    input  logic [WIDTH-1:0] Din,
    input  logic             Din_valid,
    input  logic [WIDTH-1:0] Golden,
    output logic [WIDTH-1:0] Sig,
    output logic             Busy,
    output logic             Done,
    output logic             Pass
);

    localparam int CW = $clog2(N_PATTERNS + 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPACT,
        COMPARE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CW-1:0]    count_q, count_d;
    logic             poly_q, poly_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] taps;
    logic [WIDTH-1:0] sig_step;
    logic             last_sample;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sig_q   <= SEED;
            count_q <= '0;
            poly_q  <= 1'b0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sig_q   <= sig_d;
            count_q <= count_d;
            poly_q  <= poly_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    // Galois step: shift, fold the MSB back through the taps, then mix in Din.
    always_comb begin
        taps        = poly_q ? TAPS1 : TAPS0;
        sig_step    = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? taps : '0) ^ Din;
        last_sample = (count_q == CW'(N_PATTERNS - 1));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (Start) state_d = COMPACT;
            COMPACT: if (Din_valid && last_sample) state_d = COMPARE;
            COMPARE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sig_d   = sig_q;
        count_d = count_q;
        poly_d  = poly_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    sig_d   = SEED;
                    count_d = '0;
                    poly_d  = Poly;
                    pass_d  = 1'b0;
                end
            end
            COMPACT: begin
                if (Din_valid) begin
                    sig_d   = sig_step;
                    count_d = count_q + CW'(1);
                end
            end
            COMPARE: begin
                pass_d = (sig_q == Golden);
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        Sig  = sig_q;
        Busy = (state_q != IDLE);
        Done = done_q;
        Pass = pass_q;
    end

endmodule

// File: tb/tb_misr_signature_checker.sv
// Scoreboard bench for misr_signature_checker: randomized runs checked against a
// polynomial-arithmetic signature model, plus directed reset/latency/back-to-back cases.
module tb_misr_signature_checker;

    localparam int         N     = 7;
    localparam logic [2:0] TAPS0 = 3'b011;
    localparam logic [2:0] TAPS1 = 3'b101;
    localparam logic [2:0] SEED  = 3'b000;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Start = 1'b0;
    logic       Poly = 1'b0;
    logic [2:0] Din = 3'b000;
    logic       Din_valid = 1'b0;
    logic [2:0] Golden = 3'b000;
    logic [2:0] Sig;
    logic       Busy;
    logic       Done;
    logic       Pass;

    typedef struct {
        logic [2:0] sig;
        logic       pass;
    } exp_t;

    exp_t       expQ[$];
    logic [2:0] curDin[N];
    logic [2:0] sigTrace[N];
    logic [2:0] lastExpSig = SEED;
    logic       prevDone = 1'b0;
    int         numVectors = 0;
    int         numMiscompares = 0;
    int         cycleCount = 0;
    int         startCycle = 0;
    int         doneCycle = 0;

    misr_signature_checker #(
        .WIDTH(3), .N_PATTERNS(N), .TAPS0(TAPS0), .TAPS1(TAPS1), .SEED(SEED)
    ) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Poly(Poly), .Din(Din),
        .Din_valid(Din_valid), .Golden(Golden), .Sig(Sig), .Busy(Busy),
        .Done(Done), .Pass(Pass)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cycleCount++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numVectors++;
        if (actual !== expected) begin
            numMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Multiply the signature polynomial by x modulo the feedback polynomial, then add Din.
    function automatic logic [2:0] modelStep(input logic [2:0] s, input logic [2:0] d, input logic p);
        int fullPoly;
        int v;
        fullPoly = p ? (8 | int'(TAPS1)) : (8 | int'(TAPS0));
        v = int'(s) * 2;
        if (v >= 8) v = v ^ fullPoly;
        return 3'(v) ^ d;
    endfunction

    function automatic logic [2:0] modelSignature(input logic p);
        logic [2:0] s;
        s = SEED;
        for (int i = 0; i < N; i++) s = modelStep(s, curDin[i], p);
        return s;
    endfunction

    // Monitor: every Done pulse consumes one scoreboard entry.
    always @(negedge CLK) begin
        exp_t e;
        if (RST && Done) begin
            doneCycle = cycleCount;
            checkOutput("donePulseWidth", prevDone, 1'b0);
            if (expQ.size() == 0) begin
                checkOutput("unexpectedDone", Done, 1'b0);
            end else begin
                e = expQ.pop_front();
                checkOutput("doneSig", Sig, e.sig);
                checkOutput("donePass", Pass, e.pass);
                checkOutput("doneBusy", Busy, 1'b0);
            end
        end
        prevDone = RST && Done;
    end

    task automatic applyStimulus(input logic poly, input logic [2:0] golden, input int gaps, input bit noise);
        exp_t       e;
        logic [2:0] s;
        e.sig  = modelSignature(poly);
        e.pass = (e.sig == golden);
        expQ.push_back(e);
        lastExpSig = e.sig;
        Golden    = golden;
        Start     = 1'b1;
        Poly      = poly;
        Din_valid = 1'b0;
        Din       = 3'($urandom);
        @(posedge CLK); #1;
        startCycle = cycleCount;
        Start = 1'b0;
        checkOutput("startBusy", Busy, 1'b1);
        checkOutput("startPass", Pass, 1'b0);
        checkOutput("startSig", Sig, SEED);
        s = SEED;
        for (int i = 0; i < N; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gaps; g++) begin
                    Din_valid = 1'b0;
                    Din       = 3'($urandom);
                    Start     = noise ? 1'($urandom) : 1'b0;
                    Poly      = noise ? 1'($urandom) : poly;
                    @(posedge CLK); #1;
                    checkOutput("gapHold", Sig, s);
                end
            end
            Din       = curDin[i];
            Din_valid = 1'b1;
            Start     = noise ? 1'($urandom) : 1'b0;
            Poly      = noise ? 1'($urandom) : poly;
            @(posedge CLK); #1;
            s = modelStep(s, curDin[i], poly);
            sigTrace[i] = Sig;
        end
        Start     = 1'b0;
        Poly      = poly;
        Din       = 3'($urandom);
        Din_valid = noise ? 1'($urandom) : 1'b0;
        @(posedge CLK); #1;
        Din_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            Start     = 1'b0;
            Din_valid = 1'($urandom);
            Din       = 3'($urandom);
            @(posedge CLK); #1;
            checkOutput("idleSigHold", Sig, lastExpSig);
            checkOutput("idleBusy", Busy, 1'b0);
        end
        Din_valid = 1'b0;
    endtask

    task automatic randomDin();
        for (int i = 0; i < N; i++) curDin[i] = 3'($urandom);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] g;
        logic       p;

        repeat (2) @(posedge CLK);
        #1;
        checkOutput("resetSig", Sig, SEED);
        checkOutput("resetBusy", Busy, 1'b0);
        checkOutput("resetDone", Done, 1'b0);
        checkOutput("resetPass", Pass, 1'b0);
        RST = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < N; i++) curDin[i] = 3'b001;
        applyStimulus(1'b0, modelSignature(1'b0), 0, 1'b0);
        checkOutput("poly0Step1", sigTrace[0], 3'b001);
        checkOutput("poly0Step2", sigTrace[1], 3'b011);
        checkOutput("poly0Step3", sigTrace[2], 3'b111);
        checkOutput("poly0Step4", sigTrace[3], 3'b100);
        idleCycles(2);

        applyStimulus(1'b1, modelSignature(1'b1) ^ 3'b001, 0, 1'b0);
        checkOutput("poly1Step1", sigTrace[0], 3'b001);
        checkOutput("poly1Step2", sigTrace[1], 3'b011);
        checkOutput("poly1Step3", sigTrace[2], 3'b111);
        checkOutput("poly1Step4", sigTrace[3], 3'b010);
        idleCycles(2);
        applyStimulus(1'b1, modelSignature(1'b1), 0, 1'b0);
        idleCycles(1);

        for (int i = 0; i < N; i++) curDin[i] = 3'b000;
        applyStimulus(1'($urandom), 3'b000, 0, 1'b0);
        @(negedge CLK); #1;
        checkOutput("latencyEdges", 32'(doneCycle - startCycle + 1), 32'(N + 2));
        idleCycles(2);

        randomDin();
        applyStimulus(1'b0, modelSignature(1'b0), 2, 1'b1);
        idleCycles(1);

        randomDin();
        applyStimulus(1'b1, modelSignature(1'b1), 0, 1'b0);
        randomDin();
        applyStimulus(1'b0, 3'($urandom), 0, 1'b0);
        idleCycles(2);

        // Abort a run with an asynchronous reset between clock edges.
        Start = 1'b1;
        Poly  = 1'b1;
        @(posedge CLK); #1;
        Start     = 1'b0;
        Din       = 3'b101;
        Din_valid = 1'b1;
        repeat (3) begin
            @(posedge CLK); #1;
        end
        #2;
        RST = 1'b0;
        #1;
        checkOutput("abortSig", Sig, SEED);
        checkOutput("abortBusy", Busy, 1'b0);
        checkOutput("abortDone", Done, 1'b0);
        checkOutput("abortPass", Pass, 1'b0);
        #2;
        RST = 1'b1;
        lastExpSig = SEED;
        @(posedge CLK); #1;
        idleCycles(10);

        for (int r = 0; r < 15; r++) begin
            randomDin();
            p = 1'($urandom);
            g = ($urandom_range(0, 1) == 0) ? modelSignature(p) : 3'($urandom);
            applyStimulus(p, g, $urandom_range(0, 2), 1'($urandom));
            if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(1, 3));
        end

        idleCycles(3);
        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule

// File: doc/misr_signature_checker.md
Name: misr_signature_checker

Overview:
- Response-side counterpart of the 3-bit pattern LFSR in the BIST path.
- Compacts the circuit-under-test responses into a multiple-input signature register (MISR) over a fixed pattern count.
- Compares the final signature against a golden value and reports pass or fail.
- Runs alongside the pattern generator and supports the same two feedback polynomials, selected by the same Poly convention.

Parameters:
- WIDTH, 3: signature and response width in bits.
- N_PATTERNS, 7: responses compacted per run (one full LFSR period); must be >= 1.
- TAPS0, 3'b011: Galois feedback mask when Poly=0 (x^3+x+1).
- TAPS1, 3'b101: Galois feedback mask when Poly=1 (x^3+x^2+1).
- SEED, 3'b000: signature value loaded on Start.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- Start  in  1  begin a run; sampled only in IDLE.
- Poly  in  1  polynomial select; latched on accepted Start.
- Din  in  WIDTH  response word from the circuit under test.
- Din_valid  in  1  Din is valid this cycle.
- Golden  in  WIDTH  expected signature; sampled in COMPARE.
- Sig  out  WIDTH  current signature register.
- Busy  out  1  run in progress.
- Done  out  1  one-cycle pulse when the result is valid.
- Pass  out  1  1 = last signature matched Golden; held until the next accepted Start.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, Sig=SEED, count=0, poly_q=0, Busy=0, Done=0, Pass=0. Reset mid-run aborts the run; no Done is produced.
- Counter width: clog2(N_PATTERNS+1) bits.
- Update rule for one compaction step (s = Sig, d = Din, T = poly_q ? TAPS1 : TAPS0):
  - s' = {s[WIDTH-2:0],1'b0} ^ (s[WIDTH-1] ? T : 0) ^ d
  - Pure XOR, no carries, exactly WIDTH bits.
- FSM states: IDLE, COMPACT, COMPARE.
- IDLE:
  - Start=1 at an edge: Sig<=SEED, count<=0, poly_q<=Poly, Pass<=0, Busy<=1, go to COMPACT.
  - Din_valid is ignored in IDLE.
- COMPACT:
  - Each edge with Din_valid=1: Sig<=s', count<=count+1.
  - If that sample is number N_PATTERNS (count==N_PATTERNS-1 before the edge), go to COMPARE on the same edge.
  - Din_valid=0: hold Sig and count, with no timeout.
  - Start is ignored. Poly changes have no effect (poly_q holds).
- COMPARE (exactly one cycle):
  - Next edge: Pass<=(Sig==Golden), Done<=1, Busy<=0, go to IDLE.
  - Din_valid is ignored.
- Done: high for exactly one cycle and cleared at the following edge.
- Start in the cycle Done is high: state is already IDLE, so Start is accepted. That edge loads SEED, clears Pass and asserts Busy.
- Latency: Done rises one edge after the edge that accepts the final Din.
  - Minimum run is N_PATTERNS+2 edges from Start to Done, with Din_valid held high.
- Sig holds its final value in IDLE until the next Start or reset.
- Busy: 1 from the Start edge through the COMPARE cycle; 0 after the Done edge.

Test Plan:
- Reset, then Start with Poly=0, N_PATTERNS=4, Din=3'b001 with Din_valid high for 4 cycles:
  - Sig sequence 001, 011, 111, 100.
  - With Golden=3'b100: Done pulses once, Pass=1, Busy falls together with the Done edge.
- Same stimulus with Poly=1:
  - Sig sequence 001, 011, 111, 010.
  - With Golden=3'b100: Pass=0. With Golden=3'b010: Pass=1.
- Default N_PATTERNS=7, Din=000 throughout, Golden=000:
  - Sig stays 000.
  - Done occurs exactly 9 edges after Start; Pass=1.
- Din_valid gaps and illegal inputs:
  - Toggle Din_valid 1,0,0,1,... during the run; Sig and count hold on the gap cycles and the result matches the gap-free run.
  - Start pulses and Poly toggles mid-run have no effect.
- RST low asynchronously mid-run, between clock edges:
  - Outputs go immediately to Sig=000, Busy=0, Done=0, Pass=0.
  - No Done after release; a new Start runs normally.
- Back-to-back runs:
  - Start asserted in the Done cycle begins a new run.
  - Pass clears on that edge; the second run's result is independent of the first.
